// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared FSM state type and default operand width for the serial subtractor
package sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor
module full_subtractor (
   input  logic din_A,
   input  logic din_B,
   input  logic din_bin,
   output logic dout_diff,
   output logic dout_borrow
);

   assign dout_diff   = din_A ^ din_B ^ din_bin;
   assign dout_borrow = (~din_A & din_B) | (~(din_A ^ din_B) & din_bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - bin subtractor with valid/ready handshakes
// Defining SERIAL_SUB_OVERFLOW_EN adds the dout_overflow (signed overflow) output.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din_A,
   input  logic [WIDTH-1:0] din_B,
   input  logic             din_bin,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [WIDTH-1:0] dout_diff,
   output logic             dout_borrow,
   output logic             dout_valid,
   input  logic             dout_ready
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             dout_overflow
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             step_d;
   logic             step_br;

   full_subtractor u_fs (
      .din_A      (a_sr[0]),
      .din_B      (b_sr[0]),
      .din_bin    (br),
      .dout_diff  (step_d),
      .dout_borrow(step_br)
   );

   // Result outputs are loaded only on the final bit, so they hold the last
   // result through BUSY and IDLE until the next transaction completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_sr        <= '0;
         b_sr        <= '0;
         res_sr      <= '0;
         cnt         <= '0;
         br          <= 1'b0;
         din_ready   <= 1'b1;
         dout_valid  <= 1'b0;
         dout_diff   <= '0;
         dout_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         dout_overflow <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (din_valid) begin
                  a_sr      <= din_A;
                  b_sr      <= din_B;
                  br        <= din_bin;
                  cnt       <= '0;
                  state     <= BUSY;
                  din_ready <= 1'b0;
               end
            end
            BUSY: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {step_d, res_sr[WIDTH-1:1]};
               br     <= step_br;
               if (cnt == LAST_BIT) begin
                  state       <= DONE;
                  dout_valid  <= 1'b1;
                  dout_diff   <= {step_d, res_sr[WIDTH-1:1]};
                  dout_borrow <= step_br;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  // On the last step the LSBs of the shifters are the operand MSBs.
                  dout_overflow <= (a_sr[0] ^ b_sr[0]) & (step_d ^ a_sr[0]);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (dout_ready) begin
                  state      <= IDLE;
                  dout_valid <= 1'b0;
                  din_ready  <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               dout_valid <= 1'b0;
               din_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] din_A = '0;
   logic [W-1:0] din_B = '0;
   logic         din_bin = 1'b0;
   logic         din_valid = 1'b0;
   logic         din_ready;
   logic [W-1:0] dout_diff;
   logic         dout_borrow;
   logic         dout_valid;
   logic         dout_ready = 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic         dout_overflow;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_A      (din_A),
      .din_B      (din_B),
      .din_bin    (din_bin),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout_diff  (dout_diff),
      .dout_borrow(dout_borrow),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
`ifdef SERIAL_SUB_OVERFLOW_EN
      ,
      .dout_overflow(dout_overflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       br;
      logic       ov;
      int         acc;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         pushed = 0;
   int         popped = 0;
   logic [7:0] last_d = '0;
   logic       last_br = 1'b0;
   bit         in_done = 1'b0;
   bit         rnd_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer subtraction; overflow by the sign rule on A, B, diff.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input logic bin, input int acc);
      exp_t e;
      int   full;
      full  = int'(a) - int'(b) - int'(bin);
      e.d   = full[7:0];
      e.br  = (full < 0);
      e.ov  = (a[7] != b[7]) && (e.d[7] != a[7]);
      e.acc = acc;
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst_n && din_valid && din_ready) begin
         q.push_back(model(din_A, din_B, din_bin, cyc + 1));
         pushed++;
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         in_done = 1'b0;
         last_d  = '0;
         last_br = 1'b0;
      end else begin
         if (din_ready) begin
            chk("idle_hold_diff", 32'(dout_diff), 32'(last_d));
            chk("idle_hold_borrow", 32'(dout_borrow), 32'(last_br));
            chk("idle_valid_low", 32'(dout_valid), 32'd0);
         end
         if (dout_valid) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_valid actual=1 expected=0");
            end else begin
               if (!in_done) chk("latency", 32'(cyc - q[0].acc), 32'(W));
               in_done = 1'b1;
               chk("diff", 32'(dout_diff), 32'(q[0].d));
               chk("borrow", 32'(dout_borrow), 32'(q[0].br));
`ifdef SERIAL_SUB_OVERFLOW_EN
               chk("overflow", 32'(dout_overflow), 32'(q[0].ov));
`endif
               chk("done_din_ready_low", 32'(din_ready), 32'd0);
               if (dout_ready) begin
                  last_d  = q[0].d;
                  last_br = q[0].br;
                  void'(q.pop_front());
                  popped++;
                  in_done = 1'b0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) dout_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!din_ready && n < 100) begin
         step();
         n++;
      end
      chk({name, "_ready"}, 32'(din_ready), 32'd1);
   endtask

   task automatic run_dir(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic [7:0] exp_d, input logic exp_br,
                          input logic exp_ov);
      int n = 0;
      wait_ready(name);
      din_A = a; din_B = b; din_bin = bin; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      while (!dout_valid && n < 100) begin
         step();
         n++;
      end
      chk({name, "_lat"}, 32'(n), 32'(W));
      chk({name, "_diff"}, 32'(dout_diff), 32'(exp_d));
      chk({name, "_borrow"}, 32'(dout_borrow), 32'(exp_br));
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk({name, "_ovf"}, 32'(dout_overflow), 32'(exp_ov));
`else
      if (exp_ov !== exp_ov) chk({name, "_ovf_x"}, 32'd0, 32'd1);
`endif
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_din_ready", 32'(din_ready), 32'd1);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_dout_diff", 32'(dout_diff), 32'd0);
      chk("rst_dout_borrow", 32'(dout_borrow), 32'd0);
      rst_n = 1'b1;
      step();

      e = model(8'h05, 8'h03, 1'b0, 0);
      chk("model_05_03", {23'd0, e.br, e.d}, 32'h002);
      e = model(8'h00, 8'h01, 1'b0, 0);
      chk("model_00_01", {23'd0, e.br, e.d}, 32'h1FF);
      e = model(8'h80, 8'h01, 1'b0, 0);
      chk("model_80_01_ovf", {23'd0, e.ov, e.d}, 32'h17F);

      run_dir("d_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      run_dir("d_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_dir("d_10_0f_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
      run_dir("d_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_dir("d_7f_01", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);

      // Backpressure: result must hold for 20 cycles while new operands are offered.
      dout_ready = 1'b0;
      wait_ready("stall");
      din_A = 8'h33; din_B = 8'h44; din_bin = 1'b1; din_valid = 1'b1;
      step();
      n = 0;
      while (!dout_valid && n < 100) begin
         din_valid = 1'($urandom_range(0, 1));
         din_A = 8'($urandom); din_B = 8'($urandom); din_bin = 1'($urandom);
         step();
         n++;
      end
      chk("stall_diff_start", 32'(dout_diff), 32'hEE);
      repeat (20) begin
         din_valid = 1'($urandom_range(0, 1));
         din_A = 8'($urandom); din_B = 8'($urandom); din_bin = 1'($urandom);
         step();
         chk("stall_valid", 32'(dout_valid), 32'd1);
         chk("stall_din_ready", 32'(din_ready), 32'd0);
      end
      chk("stall_diff_end", 32'(dout_diff), 32'hEE);
      chk("stall_borrow_end", 32'(dout_borrow), 32'd1);
      chk("stall_no_capture", 32'(q.size()), 32'd1);
      din_valid = 1'b0;
      dout_ready = 1'b1;
      step();
      chk("post_hs_valid", 32'(dout_valid), 32'd0);
      chk("post_hs_ready", 32'(din_ready), 32'd1);
      chk("post_hs_queue", 32'(q.size()), 32'd0);

      // Abort in the middle of BUSY.
      wait_ready("abort");
      din_A = 8'hA7; din_B = 8'h3C; din_bin = 1'b0; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      repeat (4) step();
      chk("abort_busy_valid", 32'(dout_valid), 32'd0);
      rst_n = 1'b0;
      q.delete();
      pushed = popped;
      #1;
      chk("abort_dout_valid", 32'(dout_valid), 32'd0);
      chk("abort_dout_diff", 32'(dout_diff), 32'd0);
      chk("abort_dout_borrow", 32'(dout_borrow), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("abort_release_ready", 32'(din_ready), 32'd1);
      run_dir("post_abort", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

      rnd_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wait_ready("rnd");
         din_A = 8'($urandom); din_B = 8'($urandom); din_bin = 1'($urandom);
         din_valid = 1'b1;
         step();
         din_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            din_valid = 1'($urandom_range(0, 1));
            din_A = 8'($urandom); din_B = 8'($urandom); din_bin = 1'($urandom);
            step();
         end
         din_valid = 1'b0;
      end
      rnd_ready = 1'b0;
      dout_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      step();
      chk("drain_empty", 32'(q.size()), 32'd0);
      chk("drain_count", 32'(popped), 32'(pushed));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
